multimode_ff_bank: RTL and testbench

//  Bank of WIDTH clocked storage cells. One MODE input selects how every cell

---
 rtl/ff_bank_pkg.sv | 43 ++++
 rtl/ff_cell.sv | 50 +++++
 rtl/multimode_ff_bank.sv | 68 ++++++
 tb/tb_multimode_ff_bank.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/ff_bank_pkg.sv
// ff_bank_pkg
//   Shared definitions for the multimode flip-flop bank.
//   MODE_* : 2-bit mode encodings (SR, JK, D, T).
//   ff_next: next state of one cell for a given mode, data pair and current Q.
package ff_bank_pkg;

    localparam logic [1:0] MODE_SR = 2'b00;
    localparam logic [1:0] MODE_JK = 2'b01;
    localparam logic [1:0] MODE_D  = 2'b10;
    localparam logic [1:0] MODE_T  = 2'b11;

    // a/b carry S/R, J/K, D/-, T/- depending on mode.
    // In SR mode the S=R=1 case holds; flagging it is the caller's job.
    function automatic logic ff_next(input logic [1:0] mode,
                                     input logic       a,
                                     input logic       b,
                                     input logic       q);
        logic q_next;
        q_next = q;
        case (mode)
            MODE_SR: begin
                case ({a, b})
                    2'b10:   q_next = 1'b1;
                    2'b01:   q_next = 1'b0;
                    default: q_next = q;
                endcase
            end
            MODE_JK: begin
                case ({a, b})
                    2'b10:   q_next = 1'b1;
                    2'b01:   q_next = 1'b0;
                    2'b11:   q_next = ~q;
                    default: q_next = q;
                endcase
            end
            MODE_D:  q_next = a;
            MODE_T:  q_next = q ^ a;
            default: q_next = q;
        endcase
        return q_next;
    endfunction

endpackage

// File: rtl/ff_cell.sv
// ff_cell
//   One storage bit of the multimode bank.
//   clk  : clock, state updates on posedge
//   rst  : synchronous active-high reset, loads RST_VAL
//   en   : update enable, 0 holds the cell
//   mode : SR / JK / D / T select
//   a, b : S/J/D/T and R/K inputs
//   q    : cell state
//   chg  : 1 for the cycle after an edge where q changed
//   evt  : combinational illegal-event strobe (SR mode, S=R=1, en=1)
module ff_cell
    import ff_bank_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] mode,
    input  logic       a,
    input  logic       b,
    output logic       q,
    output logic       chg,
    output logic       evt
);

    logic q_next;

    always_comb begin
        q_next = q;
        if (en) begin
            q_next = ff_next(mode, a, b, q);
        end
    end

    assign evt = en & (mode == MODE_SR) & a & b;

    // chg is registered on the same edge as q, so it is high exactly while
    // the new q is first visible. Reset never raises it.
    always_ff @(posedge clk) begin
        if (rst) begin
            q   <= RST_VAL;
            chg <= 1'b0;
        end else begin
            q   <= q_next;
            chg <= q_next ^ q;
        end
    end

endmodule

// File: rtl/multimode_ff_bank.sv
// multimode_ff_bank
//   WIDTH independent cells sharing one mode select, plus sticky per-cell
//   illegal flags and a saturating count of edges carrying any illegal event.
//   clk     : clock, all state updates on posedge
//   rst     : synchronous active-high reset (overrides en, mode, clr_err)
//   en      : cell update enable
//   mode    : 00=SR 01=JK 10=D 11=T
//   a, b    : per-cell data inputs
//   clr_err : clears illegal and err_cnt, wins over a same-edge event
//   q, qbar : cell state and its complement
//   chg     : per-cell change strobe
//   illegal : sticky per-cell S=R=1 flag
//   err_cnt : saturating count of edges with any illegal cell
module multimode_ff_bank
    import ff_bank_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned CNT_W   = 8,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [WIDTH-1:0] chg,
    output logic [WIDTH-1:0] illegal,
    output logic [CNT_W-1:0] err_cnt
);

    logic [WIDTH-1:0] evt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        ff_cell #(
            .RST_VAL (RST_VAL)
        ) u_cell (
            .clk  (clk),
            .rst  (rst),
            .en   (en),
            .mode (mode),
            .a    (a[i]),
            .b    (b[i]),
            .q    (q[i]),
            .chg  (chg[i]),
            .evt  (evt[i])
        );
    end

    assign qbar = ~q;

    // One count per edge no matter how many cells flagged; held at all-ones.
    always_ff @(posedge clk) begin
        if (rst || clr_err) begin
            illegal <= '0;
            err_cnt <= '0;
        end else begin
            illegal <= illegal | evt;
            if ((|evt) && (err_cnt != {CNT_W{1'b1}})) begin
                err_cnt <= err_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_multimode_ff_bank.sv
module tb_multimode_ff_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [3:0] a;
    logic [3:0] b;
    logic       clr_err;
    logic [3:0] q;
    logic [3:0] qbar;
    logic [3:0] chg;
    logic [3:0] illegal;
    logic [3:0] err_cnt;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [3:0] m_q, m_chg, m_ill, m_cnt;

    multimode_ff_bank #(
        .WIDTH   (4),
        .CNT_W   (4),
        .RST_VAL (1'b0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .mode    (mode),
        .a       (a),
        .b       (b),
        .clr_err (clr_err),
        .q       (q),
        .qbar    (qbar),
        .chg     (chg),
        .illegal (illegal),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        tests++;
        assert (obs === expv)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Whole-vector behavioural rules: each mode as a boolean expression on
    // the 4-bit words rather than a per-cell case table.
    task automatic model_edge();
        logic [3:0] qn, ev;
        if (rst) begin
            m_q = 4'h0; m_chg = 4'h0; m_ill = 4'h0; m_cnt = 4'h0;
        end else begin
            ev = 4'h0;
            qn = m_q;
            if (en) begin
                case (mode)
                    2'd0: begin
                        qn = (a & ~b) | (m_q & ~a & ~b) | (m_q & a & b);
                        ev = a & b;
                    end
                    2'd1: qn = (a & ~m_q) | (~b & m_q);
                    2'd2: qn = a;
                    default: qn = m_q ^ a;
                endcase
            end
            m_chg = qn ^ m_q;
            m_q   = qn;
            if (clr_err) begin
                m_ill = 4'h0;
                m_cnt = 4'h0;
            end else begin
                m_ill = m_ill | ev;
                if (ev != 4'h0 && m_cnt < 4'd15) m_cnt = m_cnt + 4'd1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("q", q, m_q);
        chk("qbar", qbar, ~m_q);
        chk("chg", chg, m_chg);
        chk("illegal", illegal, m_ill);
        chk("err_cnt", err_cnt, m_cnt);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        m_q = 4'h0; m_chg = 4'h0; m_ill = 4'h0; m_cnt = 4'h0;
        rst = 1'b1; en = 1'b1; mode = 2'b00; a = 4'hF; b = 4'hF; clr_err = 1'b0;

        // 1: reset with illegal-looking inputs
        tick();
        tick();
        chk("rst_q", q, 4'h0);
        chk("rst_qbar", qbar, 4'hF);
        chk("rst_chg", chg, 4'h0);
        chk("rst_ill", illegal, 4'h0);
        chk("rst_cnt", err_cnt, 4'h0);

        // 2: SR set / hold / clear
        rst = 1'b0; mode = 2'b00; a = 4'h1; b = 4'h0;
        tick();
        chk("sr_set_q", q, 4'h1);
        chk("sr_set_chg", chg, 4'h1);
        a = 4'h0; b = 4'h0;
        tick();
        chk("sr_hold_q", q, 4'h1);
        chk("sr_hold_chg", chg, 4'h0);
        a = 4'h0; b = 4'h1;
        tick();
        chk("sr_clr_q", q, 4'h0);
        chk("sr_clr_chg", chg, 4'h1);

        // 3: illegal events, counter saturation, clear wins
        a = 4'h5; b = 4'h5;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_q", q, 4'h0);
        chk("sat_ill", illegal, 4'h5);
        chk("sat_cnt", err_cnt, 4'hF);
        clr_err = 1'b1;
        tick();
        chk("clr_ill", illegal, 4'h0);
        chk("clr_cnt", err_cnt, 4'h0);
        clr_err = 1'b0;

        // 4: JK toggling then switch to T
        mode = 2'b01; a = 4'hF; b = 4'hF;
        tick(); chk("jk_t1", q, 4'hF); chk("jk_c1", chg, 4'hF);
        tick(); chk("jk_t2", q, 4'h0); chk("jk_c2", chg, 4'hF);
        tick(); chk("jk_t3", q, 4'hF); chk("jk_c3", chg, 4'hF);
        mode = 2'b11; a = 4'h3; b = 4'h0;
        tick(); chk("t_q", q, 4'hC);

        // 5: D mode with enable gating
        mode = 2'b10; en = 1'b0; a = 4'hA;
        tick(); chk("d_en0_q", q, 4'hC); chk("d_en0_chg", chg, 4'h0);
        en = 1'b1;
        tick(); chk("d_en1_q", q, 4'hA);

        // 6: reset in the middle of JK toggling
        mode = 2'b01; a = 4'hF; b = 4'hF;
        tick(); chk("jk_pre_rst", q, 4'h5);
        rst = 1'b1;
        tick(); chk("mid_rst_q", q, 4'h0); chk("mid_rst_chg", chg, 4'h0);
        rst = 1'b0;
        tick(); chk("post_rst_q", q, 4'hF); chk("post_rst_chg", chg, 4'hF);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst     = ($urandom_range(0, 31) == 0);
            clr_err = ($urandom_range(0, 15) == 0);
            en      = ($urandom_range(0, 3) != 0);
            mode    = 2'($urandom);
            a       = 4'($urandom);
            b       = 4'($urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
